// File: rtl/sst_pkg.sv
// ---------------------------------------------------------------------------
// sst_pkg
//   Shared definitions for the save-state (SST) engine.
//   - sst_state_e : engine FSM states
//   - DEPTH/ADDR_W: SST image size and buffer address width
//   - ID_ADDR     : mapper ID register address; it is read-only on the mapper
//                   side and is never replayed during LOAD
//   - CRC_POLY    : CRC-8 polynomial for the optional image checksum
//   - crc8_byte() : folds one byte into a running CRC-8 (MSB first)
// ---------------------------------------------------------------------------
package sst_pkg;

    localparam int DEPTH      = 128;
    localparam int ADDR_W     = $clog2(DEPTH);
    localparam int DATA_W     = 8;
    localparam int SETTLE_DEF = 2;
    localparam int M3_TO_DEF  = 4096;

    localparam logic [ADDR_W-1:0] ID_ADDR  = 7'd127;
    localparam logic [7:0]        CRC_POLY = 8'h07;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SV_SET = 3'd1,
        SV_CAP = 3'd2,
        CHK    = 3'd3,
        LD_WR  = 3'd4,
        LD_NXT = 3'd5,
        DONE   = 3'd6
    } sst_state_e;

    // Byte-wise CRC-8: xor the byte into the register, then shift eight times.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc,
                                             input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/sst_buf.sv
// ---------------------------------------------------------------------------
// sst_buf
//   128x8 state-image buffer with an engine port and a host port.
//   Both ports read with one clock of latency (registered read data).
//   The engine owns the buffer while a command runs, so the two write
//   enables are never active together; the engine port still wins if they
//   ever are. Memory contents are not reset.
//
//   Ports
//     clk, rst_n      clock, async active-low reset (read registers only)
//     eng_we          engine write strobe
//     eng_waddr/wdat  engine write address / data
//     eng_raddr       engine read address
//     eng_rdat        engine read data (registered)
//     host_en         host port enable; when low, host_rdat holds its value
//     host_we         host write strobe (already qualified by the caller)
//     host_addr/wdat  host address / write data
//     host_rdat       host read data (registered)
// ---------------------------------------------------------------------------
module sst_buf
    import sst_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              eng_we,
    input  logic [ADDR_W-1:0] eng_waddr,
    input  logic [DATA_W-1:0] eng_wdat,
    input  logic [ADDR_W-1:0] eng_raddr,
    output logic [DATA_W-1:0] eng_rdat,
    input  logic              host_en,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdat,
    output logic [DATA_W-1:0] host_rdat
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (eng_we) begin
            mem[eng_waddr] <= eng_wdat;
        end else if (host_we) begin
            mem[host_addr] <= host_wdat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_rdat <= '0;
        end else begin
            eng_rdat <= mem[eng_raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_rdat <= '0;
        end else if (host_en) begin
            host_rdat <= mem[host_addr];
        end
    end

endmodule

// File: rtl/sst_engine.sv
// ---------------------------------------------------------------------------
// sst_engine
//   Save-state initiator sitting between the host/menu CPU and the active
//   mapper. SAVE walks SST addresses 0..DEPTH-1 and captures each byte read
//   from the mapper into the buffer. LOAD first compares the mapper ID at
//   ID_ADDR against the buffered copy, then replays bytes 0..ID_ADDR-1 with
//   sst_we_reg, each write completing on the clock edge where cpu_m3 is high.
//
//   Command handshake: cmd_save / cmd_load are single-clock pulses accepted
//   only in IDLE (cmd_save wins a tie); busy rises on the accepting edge and
//   stays high through the one-clock done pulse. Pulses seen while busy are
//   dropped.
//
//   Parameters
//     SETTLE  clocks sst_addr is held before sst_di is sampled
//     M3_TO   clocks to wait for cpu_m3 on one write before aborting with err
//
//   Ports
//     clk, rst_n          clock, async active-low reset
//     cmd_save, cmd_load  command pulses
//     busy, done, err     status (err is sticky until the next command)
//     host_addr/we/wdat   host buffer port (writes ignored while busy)
//     host_rdat           host read data, 1 clk latency, held while busy
//     sst_act_mc          SST session active
//     sst_we_reg          SST register write strobe
//     sst_addr, sst_dato  SST register address / write data
//     sst_di              SST read data from the mapper
//     cpu_m3              CPU write-phase qualifier
//     crc                 CRC-8 of the last SAVE image (only with SST_CRC_EN)
//     state_dbg           current FSM state
//
//   Build option: define SST_CRC_EN to add the crc output and its logic.
// ---------------------------------------------------------------------------
module sst_engine
    import sst_pkg::*;
#(
    parameter int SETTLE = SETTLE_DEF,
    parameter int M3_TO  = M3_TO_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_save,
    input  logic              cmd_load,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic              host_we,
    input  logic [DATA_W-1:0] host_wdat,
    output logic [DATA_W-1:0] host_rdat,
    output logic              sst_act_mc,
    output logic              sst_we_reg,
    output logic [7:0]        sst_addr,
    output logic [7:0]        sst_dato,
    input  logic [7:0]        sst_di,
    input  logic              cpu_m3,
`ifdef SST_CRC_EN
    output logic [7:0]        crc,
`endif
    output sst_state_e        state_dbg
);

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int TO_W  = (M3_TO > 1)  ? $clog2(M3_TO)  : 1;

    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(M3_TO - 1);
    localparam logic [ADDR_W-1:0] SAVE_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LOAD_LAST = ID_ADDR - ADDR_W'(1);

    sst_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SET_W-1:0]  set_q, set_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              err_q, err_d;

    logic              eng_we;
    logic [DATA_W-1:0] eng_rdat;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            set_q   <= '0;
            to_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            set_q   <= set_d;
            to_q    <= to_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // The buffer read address is addr_d, so the registered read data
    // already holds buf[addr_q] in the cycle after any address change. This
    // lets CHK compare against buf[ID_ADDR] and LD_WR drive buf[a] on
    // sst_dato without extra wait states.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        set_d   = set_q;
        to_d    = to_q;
        err_d   = err_q;
        eng_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_save) begin
                    state_d = SV_SET;
                    addr_d  = '0;
                    set_d   = '0;
                    err_d   = 1'b0;
                end else if (cmd_load) begin
                    state_d = CHK;
                    addr_d  = ID_ADDR;
                    set_d   = '0;
                    err_d   = 1'b0;
                end
            end

            SV_SET: begin
                if (set_q == SET_LAST) begin
                    set_d   = '0;
                    state_d = SV_CAP;
                end else begin
                    set_d = set_q + SET_W'(1);
                end
            end

            SV_CAP: begin
                eng_we = 1'b1;
                if (addr_q == SAVE_LAST) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = SV_SET;
                end
            end

            CHK: begin
                if (set_q == SET_LAST) begin
                    set_d = '0;
                    if (sst_di != eng_rdat) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        addr_d  = '0;
                        to_d    = '0;
                        state_d = LD_WR;
                    end
                end else begin
                    set_d = set_q + SET_W'(1);
                end
            end

            LD_WR: begin
                // The mapper latches on the edge where cpu_m3 and we_reg are
                // both high; that same edge ends the write.
                if (cpu_m3) begin
                    to_d    = '0;
                    state_d = LD_NXT;
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end

            LD_NXT: begin
                if (addr_q == LOAD_LAST) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    to_d    = '0;
                    state_d = LD_WR;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from reset-cleared registers, so an async reset
    // drops the bus immediately.
    // ------------------------------------------------------------------
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign err        = err_q;
    assign sst_act_mc = busy && !done;
    assign sst_we_reg = (state_q == LD_WR);
    assign sst_addr   = sst_act_mc ? 8'(addr_q) : 8'h00;
    assign sst_dato   = sst_we_reg ? eng_rdat : 8'h00;
    assign state_dbg  = state_q;

    // ------------------------------------------------------------------
    // Buffer
    // ------------------------------------------------------------------
    sst_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .eng_we    (eng_we),
        .eng_waddr (addr_q),
        .eng_wdat  (sst_di),
        .eng_raddr (addr_d),
        .eng_rdat  (eng_rdat),
        .host_en   (!busy),
        .host_we   (host_we && !busy),
        .host_addr (host_addr),
        .host_wdat (host_wdat),
        .host_rdat (host_rdat)
    );

`ifdef SST_CRC_EN
    // ------------------------------------------------------------------
    // Image checksum: restarted when a SAVE is accepted, updated on every
    // captured byte, left alone by LOAD.
    // ------------------------------------------------------------------
    logic [7:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (state_q == IDLE && cmd_save) begin
            crc_d = 8'h00;
        end else if (state_q == SV_CAP) begin
            crc_d = crc8_byte(crc_q, sst_di);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;
`endif

endmodule
